adc_reader: RTL and testbench
=============================

# adc_reader

SPI master front end for the 12-bit serial ADC that feeds the FFT datapath inside `top`. Each request runs one conversion frame: it drives `adc_cs`/`adc_clk`, shifts in `adc_sd` and discards the leading zero bits. It then presents the sample, optionally converted from offset binary to two's complement, with a one-cycle `valid` strobe to the windowing/FFT input stage. It is the stage between the `adc_cs`/`adc_clk`/`adc_sd` pins and the bin computation.

## Interface

Parameters:
- `WIDTH`, 12: sample width in bits.
- `LEAD_BITS`, 4: leading bits per frame, expected zero, discarded.
- `FRAME_BITS`, 16: total adc_clk periods per frame. Must be ≥ LEAD_BITS+WIDTH. Trailing bits are ignored.
- `CLK_DIV`, 2: clk cycles per adc_clk half-period. Must be ≥1.
- `QUIET_CYCLES`, 4: clk cycles with cs high after a frame. Must be ≥1.
- `SIGNED`, 1: 1 = invert MSB (offset binary → two's complement); 0 = raw code.

Ports:
- `clk` input 1: system clock; all logic is on the rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: conversion request. Sampled only in IDLE.
- `adc_sd` input 1: serial data from the ADC, MSB first.
- `adc_cs` output 1: ADC chip select, active low. Registered.
- `adc_clk` output 1: ADC serial clock, idles high. Registered.
- `sample` output WIDTH: last converted sample. Holds until the next valid.
- `valid` output 1: one-cycle pulse when `sample` updates.
- `frame_err` output 1: qualified by `valid`; 1 if any lead bit was nonzero.
- `busy` output 1: high in every state except IDLE.

## Operation

- Reset values: state IDLE, `adc_cs`=1, `adc_clk`=1, `sample`=0, `valid`=0, `frame_err`=0, `busy`=0. Shift register and counters are cleared.
- IDLE: `adc_cs`=1, `adc_clk`=1. When `start`=1, go to SETUP on the next edge.
- SETUP: `adc_cs`=0, `adc_clk`=1 for CLK_DIV cycles, then go to SHIFT.
- SHIFT: repeats for FRAME_BITS bit periods, counting bit index 0..FRAME_BITS-1.
  - Each bit period drives `adc_clk`=0 for CLK_DIV cycles, then `adc_clk`=1 for CLK_DIV cycles.
  - `adc_sd` is captured at the edge that drives `adc_clk` 0→1, i.e. the last cycle of the low phase.
  - Bits with index < LEAD_BITS are ORed into an error flag.
  - Bits with index LEAD_BITS..LEAD_BITS+WIDTH-1 shift into the data register MSB first.
  - Later bits are ignored.
- After the high phase of the last bit, go to QUIET.
  - On that edge, load `sample` ← code, with the MSB inverted if SIGNED=1.
  - On that edge, load `frame_err` ← error flag, and set `valid`=1 for exactly one cycle.
- QUIET: `adc_cs`=1, `adc_clk`=1 for QUIET_CYCLES cycles, then go to IDLE.
- `start` in any state other than IDLE is ignored; requests are not queued.
- Reset mid-frame: on the next edge, `adc_cs`=1, `adc_clk`=1, state IDLE, `valid`=0, `sample`=0. No partial sample is emitted.
- SIGNED=1 mapping: 0x000 → 0x800 (-2048), 0x800 → 0x000, 0xFFF → 0x7FF.

## Timing

- Take `start` high in IDLE at cycle 0.
  - `adc_cs` falls at cycle 1.
  - The first `adc_clk` falling edge is at cycle 1+CLK_DIV.
  - `valid` is high at cycle T_v = 1 + CLK_DIV + 2·CLK_DIV·FRAME_BITS. With defaults, T_v = 67.
  - `adc_cs` rises at T_v, the same cycle as `valid`.
  - State returns to IDLE at cycle T_v + QUIET_CYCLES = 71 with defaults.
- With `start` held high, the frame period is 1 + CLK_DIV + 2·CLK_DIV·FRAME_BITS + QUIET_CYCLES. With defaults this is 71 cycles, so `valid` rises at cycles 67, 138, 209, …
- `busy` is high from cycle 1 through the last QUIET cycle.
- No combinational path exists from `adc_sd` or `start` to any output.

## Test plan

- Defaults, SIGNED=0; ADC model returns 0000_1010_1011_1100; pulse `start` at cycle 0 → `valid` only at cycle 67 with `sample`=0xABC and `frame_err`=0; `adc_cs` low for cycles 1..66; exactly 16 `adc_clk` rising edges.
- SIGNED=1; codes 0x000, 0x800, 0xFFF in back-to-back frames → `sample` = 0x800, 0x000, 0x7FF.
- `start` held high → `valid` at cycles 67, 138, 209; `busy` low for exactly one cycle between frames.
- Lead bit 1 set, frame 0100_0000_0000_0001 → `sample`=0x001 and `frame_err`=1 with `valid`. The next clean frame → `frame_err`=0.
- `reset` asserted at cycle 30 mid-SHIFT → at cycle 31 `adc_cs`=1, `adc_clk`=1, `busy`=0, `sample`=0; no `valid` for that frame. A new `start` then completes normally after 67 cycles.
- `start` pulsed at cycles 10 and 68 (SHIFT and QUIET) → ignored; only one `valid` is produced, at cycle 67.

Source files
------------

// File: rtl/adc_reader.sv
// adc_reader: SPI master front end for a 12-bit serial ADC with optional offset-binary to two's complement conversion
module adc_reader #(
    parameter int WIDTH        = 12,
    parameter int LEAD_BITS    = 4,
    parameter int FRAME_BITS   = 16,
    parameter int CLK_DIV      = 2,
    parameter int QUIET_CYCLES = 4,
    parameter bit SIGNED       = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             adc_sd,
    output logic             adc_cs,
    output logic             adc_clk,
    output logic [WIDTH-1:0] sample,
    output logic             valid,
    output logic             frame_err,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, QUIET} state_t;

    localparam int CMAX = (CLK_DIV > QUIET_CYCLES) ? CLK_DIV : QUIET_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int BW   = $clog2(FRAME_BITS + 1);
    localparam logic [CW-1:0]    DIV_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]    QUIET_LAST = CW'(QUIET_CYCLES - 1);
    localparam logic [BW-1:0]    BIT_LAST   = BW'(FRAME_BITS - 1);
    localparam logic [BW-1:0]    LEAD_END   = BW'(LEAD_BITS);
    localparam logic [BW-1:0]    DATA_END   = BW'(LEAD_BITS + WIDTH);
    localparam logic [WIDTH-1:0] MSB_FLIP   = SIGNED ? {1'b1, {(WIDTH-1){1'b0}}} : '0;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic             high_q, high_d;
    logic             cs_q, cs_d;
    logic             sclk_q, sclk_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] sample_q, sample_d;
    logic             valid_q, valid_d;
    logic             frame_err_q, frame_err_d;

    logic div_done, quiet_done, last_bit;

    assign div_done   = cnt_q == DIV_LAST;
    assign quiet_done = cnt_q == QUIET_LAST;
    assign last_bit   = bit_q == BIT_LAST;

    // State and datapath registers; reset returns the pins to their idle levels
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            high_q      <= 1'b0;
            cs_q        <= 1'b1;
            sclk_q      <= 1'b1;
            shreg_q     <= '0;
            err_q       <= 1'b0;
            sample_q    <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            high_q      <= high_d;
            cs_q        <= cs_d;
            sclk_q      <= sclk_d;
            shreg_q     <= shreg_d;
            err_q       <= err_d;
            sample_q    <= sample_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next-state: a frame ends after the high phase of the last bit
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = start ? SETUP : IDLE;
            SETUP:   state_d = div_done ? SHIFT : SETUP;
            SHIFT:   state_d = (div_done && high_q && last_bit) ? QUIET : SHIFT;
            QUIET:   state_d = quiet_done ? IDLE : QUIET;
            default: state_d = IDLE;
        endcase
    end

    // Counters, bit capture and registered pin levels derived from the upcoming state
    always_comb begin
        cnt_d       = (state_d != state_q) ? '0 : cnt_q + 1'b1;
        bit_d       = bit_q;
        high_d      = high_q;
        shreg_d     = shreg_q;
        err_d       = err_q;
        sample_d    = sample_q;
        valid_d     = 1'b0;
        frame_err_d = frame_err_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    bit_d   = '0;
                    high_d  = 1'b0;
                    shreg_d = '0;
                    err_d   = 1'b0;
                end
            end
            SHIFT: begin
                if (div_done) begin
                    cnt_d = '0;
                    if (!high_q) begin
                        high_d = 1'b1;
                        err_d  = err_q | ((bit_q < LEAD_END) & adc_sd);
                        if (bit_q >= LEAD_END && bit_q < DATA_END)
                            shreg_d = {shreg_q[WIDTH-2:0], adc_sd};
                    end else begin
                        high_d = 1'b0;
                        bit_d  = bit_q + 1'b1;
                        if (last_bit) begin
                            sample_d    = shreg_q ^ MSB_FLIP;
                            frame_err_d = err_q;
                            valid_d     = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
        cs_d   = !(state_d == SETUP || state_d == SHIFT);
        sclk_d = !(state_d == SHIFT && !high_d);
    end

    assign adc_cs    = cs_q;
    assign adc_clk   = sclk_q;
    assign sample    = sample_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_adc_reader.sv
// tb_adc_reader: directed checks of adc_reader framing, timing, sign conversion and reset behaviour
module tb_adc_reader;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        adc_sd;
    logic        cs0, sclk0, valid0, ferr0, busy0;
    logic        cs1, sclk1, valid1, ferr1, busy1;
    logic [11:0] sample0, sample1;
    logic [15:0] frame_word;
    int          idx;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    adc_reader #(.SIGNED(1'b0)) u0 (
        .clk(clk), .reset(reset), .start(start), .adc_sd(adc_sd),
        .adc_cs(cs0), .adc_clk(sclk0), .sample(sample0), .valid(valid0),
        .frame_err(ferr0), .busy(busy0)
    );

    adc_reader #(.SIGNED(1'b1)) u1 (
        .clk(clk), .reset(reset), .start(start), .adc_sd(adc_sd),
        .adc_cs(cs1), .adc_clk(sclk1), .sample(sample1), .valid(valid1),
        .frame_err(ferr1), .busy(busy1)
    );

    // ADC model: presents the next frame bit, MSB first, after each adc_clk fall
    always @(negedge cs0) idx = 0;
    always @(negedge sclk0) begin
        if (!cs0 && idx < 16) begin
            adc_sd = frame_word[15 - idx];
            idx++;
        end
    end

    // Pulses start, returns the valid cycle and captured outputs, then waits for IDLE
    task automatic do_frame(input logic [15:0] word, output int vcyc,
                            output logic [11:0] s0, output logic [11:0] s1, output logic e);
        frame_word = word;
        vcyc = -1;
        s0 = 'x;
        s1 = 'x;
        e = 1'bx;
        @(negedge clk) start = 1'b1;
        for (int c = 1; c <= 120; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (valid0 && vcyc < 0) begin
                vcyc = c;
                s0 = sample0;
                s1 = sample1;
                e = ferr0;
            end
            if (vcyc >= 0 && !busy0) break;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (cs0 !== 1'b1) begin errors++; $display("FAIL reset_cs: got %b want 1", cs0); end
        checks++; if (sclk0 !== 1'b1) begin errors++; $display("FAIL reset_clk: got %b want 1", sclk0); end
        checks++; if (sample0 !== 12'h000) begin errors++; $display("FAIL reset_sample: got %h want 000", sample0); end
        checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid0); end
        checks++; if (ferr0 !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", ferr0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy0); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic;
        int nval = 0, vcyc = -1, cs_low = 0, first = -1, last = -1, rises = 0;
        logic prev, busy70 = 1'b0, busy71 = 1'b1, e = 1'bx;
        logic [11:0] s0 = 'x, s1 = 'x;
        frame_word = 16'h0ABC;
        @(negedge clk) start = 1'b1;
        prev = sclk0;
        for (int c = 1; c <= 75; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (!cs0) begin
                cs_low++;
                if (first < 0) first = c;
                last = c;
            end
            if (sclk0 && !prev) rises++;
            prev = sclk0;
            if (valid0) begin
                nval++;
                vcyc = c;
                s0 = sample0;
                s1 = sample1;
                e = ferr0;
            end
            if (c == 70) busy70 = busy0;
            if (c == 71) busy71 = busy0;
        end
        checks++; if (nval !== 1) begin errors++; $display("FAIL basic_nvalid: got %0d want 1", nval); end
        checks++; if (vcyc !== 67) begin errors++; $display("FAIL basic_vcycle: got %0d want 67", vcyc); end
        checks++; if (s0 !== 12'hABC) begin errors++; $display("FAIL basic_sample_raw: got %h want abc", s0); end
        checks++; if (s1 !== 12'h2BC) begin errors++; $display("FAIL basic_sample_signed: got %h want 2bc", s1); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL basic_ferr: got %b want 0", e); end
        checks++; if (cs_low !== 66 || first !== 1 || last !== 66) begin errors++; $display("FAIL basic_cs_window: got %0d cycles %0d..%0d want 66 cycles 1..66", cs_low, first, last); end
        checks++; if (rises !== 16) begin errors++; $display("FAIL basic_clk_rises: got %0d want 16", rises); end
        checks++; if (busy70 !== 1'b1 || busy71 !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b%b want 10", busy70, busy71); end
        checks++; if (sample0 !== 12'hABC || valid0 !== 1'b0) begin errors++; $display("FAIL basic_hold: got %h/%b want abc/0", sample0, valid0); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] words [3] = '{16'h0000, 16'h0800, 16'h0FFF};
        logic [11:0] exp0 [3] = '{12'h000, 12'h800, 12'hFFF};
        logic [11:0] exp1 [3] = '{12'h800, 12'h000, 12'h7FF};
        int vc [3] = '{67, 138, 209};
        int k = 0, busy_low = 0;
        frame_word = words[0];
        @(negedge clk) start = 1'b1;
        for (int c = 1; c <= 215 && k < 3; c++) begin
            @(negedge clk);
            if (!busy0) busy_low++;
            if (valid0) begin
                checks++; if (c !== vc[k]) begin errors++; $display("FAIL b2b_vcycle%0d: got %0d want %0d", k, c, vc[k]); end
                checks++; if (sample0 !== exp0[k]) begin errors++; $display("FAIL b2b_raw%0d: got %h want %h", k, sample0, exp0[k]); end
                checks++; if (sample1 !== exp1[k]) begin errors++; $display("FAIL b2b_signed%0d: got %h want %h", k, sample1, exp1[k]); end
                k++;
                if (k < 3) frame_word = words[k];
            end
        end
        checks++; if (k !== 3) begin errors++; $display("FAIL b2b_frames: got %0d want 3", k); end
        checks++; if (busy_low !== 2) begin errors++; $display("FAIL b2b_busy_gap: got %0d want 2", busy_low); end
        start = 1'b0;
        for (int c = 0; c < 80 && busy0; c++) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_frame_err;
        int vcyc;
        logic [11:0] s0, s1;
        logic e;
        do_frame(16'h4001, vcyc, s0, s1, e);
        checks++; if (vcyc !== 67) begin errors++; $display("FAIL err_vcycle: got %0d want 67", vcyc); end
        checks++; if (s0 !== 12'h001) begin errors++; $display("FAIL err_sample: got %h want 001", s0); end
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_flag: got %b want 1", e); end
        do_frame(16'h0123, vcyc, s0, s1, e);
        checks++; if (s0 !== 12'h123) begin errors++; $display("FAIL clean_sample: got %h want 123", s0); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL clean_flag: got %b want 0", e); end
    endtask

    task automatic test_reset_mid;
        int nval = 0, vcyc;
        logic [11:0] s0, s1;
        logic e;
        frame_word = 16'h0FFF;
        @(negedge clk) start = 1'b1;
        for (int c = 1; c <= 31; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (valid0) nval++;
            if (c == 30) reset = 1'b1;
        end
        checks++; if (cs0 !== 1'b1 || sclk0 !== 1'b1) begin errors++; $display("FAIL rmid_pins: got cs=%b clk=%b want 1 1", cs0, sclk0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", busy0); end
        checks++; if (sample0 !== 12'h000) begin errors++; $display("FAIL rmid_sample: got %h want 000", sample0); end
        reset = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (valid0) nval++;
        end
        checks++; if (nval !== 0) begin errors++; $display("FAIL rmid_novalid: got %0d want 0", nval); end
        do_frame(16'h0555, vcyc, s0, s1, e);
        checks++; if (vcyc !== 67) begin errors++; $display("FAIL rmid_restart_vcycle: got %0d want 67", vcyc); end
        checks++; if (s0 !== 12'h555) begin errors++; $display("FAIL rmid_restart_sample: got %h want 555", s0); end
    endtask

    task automatic test_ignore_start;
        int nval = 0, vcyc = -1;
        logic busy72 = 1'b1;
        frame_word = 16'h0321;
        @(negedge clk) start = 1'b1;
        for (int c = 1; c <= 150; c++) begin
            @(negedge clk);
            if (valid0) begin
                nval++;
                vcyc = c;
            end
            if (c == 72) busy72 = busy0;
            start = (c == 10 || c == 68);
        end
        checks++; if (nval !== 1 || vcyc !== 67) begin errors++; $display("FAIL ignore_valid: got %0d at %0d want 1 at 67", nval, vcyc); end
        checks++; if (busy72 !== 1'b0) begin errors++; $display("FAIL ignore_busy72: got %b want 0", busy72); end
        checks++; if (sample0 !== 12'h321) begin errors++; $display("FAIL ignore_sample: got %h want 321", sample0); end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        adc_sd = 1'b0;
        frame_word = '0;
        test_reset;
        test_basic;
        test_back_to_back;
        test_frame_err;
        test_reset_mid;
        test_ignore_start;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
